// File: rtl/uart_rx_framed_pkg.sv
// Shared definitions for the framed UART receiver: parity modes, FSM states
// and the default bit period for a 12 MHz clock at 115200 baud.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int DEFAULT_CLKS_PER_BIT = 104;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DELIVER,
        WAIT_HIGH
    } rx_state_t;

    // Timer reload that lands the first sample in the middle of the start bit.
    function automatic int half_bit_load(input int clks_per_bit);
        return clks_per_bit / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_rx_framed_if.sv
// Valid/ready word interface between the UART receiver (master) and its
// consumer (slave), carrying the received word and its error flags.
interface uart_rx_framed_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] o_data;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_frame_err;
    logic                 o_parity_err;
    logic                 o_overrun;

    modport master (
        output o_data,
        output o_valid,
        output o_frame_err,
        output o_parity_err,
        output o_overrun,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        input  o_frame_err,
        input  o_parity_err,
        input  o_overrun,
        output i_ready
    );
endinterface

// File: rtl/uart_rx_framed_baud_timer.sv
// Loadable down-counter producing a one-cycle tick when it reaches zero;
// shared between the UART receiver and transmitter.
module uart_baud_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                            hwclk,
    input  logic                            rst,
    input  logic                            i_load,
    input  logic [$clog2(CLKS_PER_BIT)-1:0] i_load_val,
    output logic                            o_tick
);
    localparam int W = $clog2(CLKS_PER_BIT);

    logic [W-1:0] r_count;
    logic         r_armed;

    // The armed flag keeps the tick to a single cycle once the count is spent.
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_armed <= 1'b0;
        end else if (i_load) begin
            r_count <= i_load_val;
            r_armed <= 1'b1;
        end else if (r_armed) begin
            if (r_count == '0) begin
                r_armed <= 1'b0;
            end else begin
                r_count <= r_count - W'(1);
            end
        end
    end

    assign o_tick = r_armed && (r_count == '0);

endmodule

// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver with framing/parity/overrun checks and a
// one-entry holding register. Optional break detection: UART_RX_BREAK_DET_EN.
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic             hwclk,
    input  logic             rst,
    input  logic             rx_serial,
    uart_rx_framed_if.master rx_if,
`ifdef UART_RX_BREAK_DET_EN
    output logic             o_break,
`endif
    output logic             o_busy
);
    localparam int              TW        = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]   HALF_LOAD = TW'(half_bit_load(CLKS_PER_BIT));
    localparam logic [TW-1:0]   FULL_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]      LAST_STOP = 4'(STOP_BITS - 1);

    logic                 r_sync1, r_sync2;
    logic                 w_rx;
    rx_state_t            r_state, w_next_state;
    logic                 w_load;
    logic [TW-1:0]        w_load_val;
    logic                 w_tick;
    logic [DATA_BITS-1:0] r_shift;
    logic [3:0]           r_bit_cnt;
    logic                 r_par_bit;
    logic                 r_frame_err;
    logic                 r_last_stop;
    logic                 w_parity_err;
    logic                 w_is_break;
    logic                 w_deliver;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid, r_frame_err_q, r_parity_err_q, r_overrun;

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_serial;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx = r_sync2;

    uart_baud_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .hwclk     (hwclk),
        .rst       (rst),
        .i_load    (w_load),
        .i_load_val(w_load_val),
        .o_tick    (w_tick)
    );

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_val   = FULL_LOAD;
        case (r_state)
            IDLE: begin
                if (!w_rx) begin
                    w_next_state = START;
                    w_load       = 1'b1;
                    w_load_val   = HALF_LOAD;
                end
            end
            START: begin
                if (w_tick) begin
                    w_next_state = w_rx ? IDLE : DATA;
                    w_load       = !w_rx;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_load = 1'b1;
                    if (r_bit_cnt == LAST_DATA) begin
                        w_next_state = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_load       = 1'b1;
                    w_next_state = STOP;
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_bit_cnt == LAST_STOP) begin
                        w_next_state = DELIVER;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            DELIVER: begin
                w_next_state = (w_is_break || !r_last_stop) ? WAIT_HIGH : IDLE;
            end
            WAIT_HIGH: begin
                if (w_rx) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Frame datapath: the bit counter is shared by the data and stop phases.
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            r_shift     <= '0;
            r_bit_cnt   <= 4'd0;
            r_par_bit   <= 1'b0;
            r_frame_err <= 1'b0;
            r_last_stop <= 1'b0;
        end else if (w_tick) begin
            case (r_state)
                START: begin
                    r_bit_cnt   <= 4'd0;
                    r_frame_err <= 1'b0;
                end
                DATA: begin
                    r_shift   <= {w_rx, r_shift[DATA_BITS-1:1]};
                    r_bit_cnt <= (r_bit_cnt == LAST_DATA) ? 4'd0 : r_bit_cnt + 4'd1;
                end
                PARITY: begin
                    r_par_bit <= w_rx;
                end
                STOP: begin
                    if (!w_rx) begin
                        r_frame_err <= 1'b1;
                    end
                    r_last_stop <= w_rx;
                    r_bit_cnt   <= (r_bit_cnt == LAST_STOP) ? 4'd0 : r_bit_cnt + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign w_parity_err = (PARITY_MODE != PARITY_NONE) &&
                          ((^{r_shift, r_par_bit}) != (PARITY_MODE == PARITY_ODD));

`ifdef UART_RX_BREAK_DET_EN
    logic r_first_stop_low;

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            r_first_stop_low <= 1'b0;
        end else if (r_state == STOP && w_tick && r_bit_cnt == 4'd0) begin
            r_first_stop_low <= !w_rx;
        end
    end

    assign w_is_break = (r_shift == '0) && (PARITY_MODE == PARITY_NONE || !r_par_bit) &&
                        r_first_stop_low;
    assign o_break    = (r_state == DELIVER) && w_is_break;
`else
    assign w_is_break = 1'b0;
`endif

    assign w_deliver = (r_state == DELIVER) && !w_is_break;

    // A word may load into a register being emptied in the same cycle.
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            r_data         <= '0;
            r_valid        <= 1'b0;
            r_frame_err_q  <= 1'b0;
            r_parity_err_q <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_deliver && (!r_valid || rx_if.i_ready)) begin
                r_data         <= r_shift;
                r_frame_err_q  <= r_frame_err;
                r_parity_err_q <= w_parity_err;
                r_valid        <= 1'b1;
            end else begin
                if (r_valid && rx_if.i_ready) begin
                    r_valid <= 1'b0;
                end
                if (w_deliver) begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign rx_if.o_data       = r_data;
    assign rx_if.o_valid      = r_valid;
    assign rx_if.o_frame_err  = r_frame_err_q;
    assign rx_if.o_parity_err = r_parity_err_q;
    assign rx_if.o_overrun    = r_overrun;
    assign o_busy             = (r_state != IDLE);

endmodule
